// File: rtl/mem_morpher_write_serializer.sv
// Replays one masked 256-bit line write as ascending byte writes to a byte-wide memory port,
// then returns a completion response carrying the number of bytes written.
module mem_morpher_write_serializer #(
  parameter int LINE_BYTES = 32,
  parameter int MEM_AW     = 31
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [63:0]                        req_addr,
  input  logic [8*LINE_BYTES-1:0]            req_data,
  input  logic [LINE_BYTES-1:0]              req_mask,
  output logic                               mem_wvalid,
  input  logic                               mem_wready,
  output logic [MEM_AW-1:0]                  mem_waddr,
  output logic [7:0]                         mem_wdata,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [$clog2(LINE_BYTES+1)-1:0]    resp_bytes,
  output logic                               busy
);

  localparam int CW = $clog2(LINE_BYTES + 1);
  localparam int IW = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      en_q;
  logic [MEM_AW-1:0]         addr_q, addr_d;
  logic [8*LINE_BYTES-1:0]   data_q, data_d;
  logic [LINE_BYTES-1:0]     mask_q, mask_d;
  logic [CW-1:0]             bytes_q, bytes_d;
  logic [IW-1:0]             idx;
  logic                      accept;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[63:MEM_AW];

  function automatic logic [CW-1:0] popcount(input logic [LINE_BYTES-1:0] m);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      cnt = cnt + CW'(m[i]);
    end
    return cnt;
  endfunction

  // Lowest remaining enabled byte: scanning downward leaves the smallest set index last.
  always_comb begin
    idx = '0;
    for (int i = LINE_BYTES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        idx = IW'(i);
      end
    end
  end

  // en_q holds off req_ready until the first edge after reset is released.
  assign req_ready  = (state_q == IDLE) && en_q;
  assign accept     = req_valid && req_ready;
  assign mem_wvalid = (state_q == WRITE);
  assign mem_waddr  = addr_q + MEM_AW'(idx);
  assign mem_wdata  = data_q[8*idx +: 8];
  assign resp_valid = (state_q == RESP);
  assign resp_bytes = bytes_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    bytes_d = bytes_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr[MEM_AW-1:0];
          data_d  = req_data;
          mask_d  = req_mask;
          bytes_d = popcount(req_mask);
          state_d = (req_mask != '0) ? WRITE : RESP;
        end
      end
      WRITE: begin
        if (mem_wready) begin
          mask_d[idx] = 1'b0;
          if (mask_d == '0) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

// File: tb/tb_mem_morpher_write_serializer.sv
// Directed bench for the line write serializer: checks reset state, byte ordering,
// address wrap, stalls, response back-pressure and mid-operation reset.
module tb_mem_morpher_write_serializer;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_addr;
  logic [255:0]  req_data;
  logic [31:0]   req_mask;
  logic          mem_wvalid;
  logic          mem_wready;
  logic [30:0]   mem_waddr;
  logic [7:0]    mem_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [5:0]    resp_bytes;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [255:0] pattern;

  mem_morpher_write_serializer dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_mask   (req_mask),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_bytes (resp_bytes),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a request at a negedge and returns at the negedge of cycle 1 with req_valid dropped.
  task automatic applyStimulus(input logic [63:0] addr, input logic [31:0] mask, input logic [255:0] data);
    req_addr  = addr;
    req_mask  = mask;
    req_data  = data;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) pattern[8*i +: 8] = 8'(i);
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_mask   = '0;
    mem_wready = 1'b1;
    resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_wvalid", 64'(mem_wvalid), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_resp_bytes", 64'(resp_bytes), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_waddr", 64'(mem_waddr), 64'd0);
    checkOutput("rst_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_req_ready_low", 64'(req_ready), 64'd0);
    @(negedge clock);
    checkOutput("rel_req_ready_high", 64'(req_ready), 64'd1);

    $display("[TB] test 1: full mask");
    applyStimulus(64'h8000_1000, 32'hFFFF_FFFF, pattern);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("t1_wvalid_%0d", i), 64'(mem_wvalid), 64'd1);
      checkOutput($sformatf("t1_waddr_%0d", i), 64'(mem_waddr), 64'h1000 + 64'(i));
      checkOutput($sformatf("t1_wdata_%0d", i), 64'(mem_wdata), 64'(i));
      checkOutput($sformatf("t1_req_ready_%0d", i), 64'(req_ready), 64'd0);
      @(negedge clock);
    end
    checkOutput("t1_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("t1_resp_bytes", 64'(resp_bytes), 64'd32);
    checkOutput("t1_resp_wvalid", 64'(mem_wvalid), 64'd0);
    @(negedge clock);
    checkOutput("t1_idle_busy", 64'(busy), 64'd0);
    checkOutput("t1_idle_req_ready", 64'(req_ready), 64'd1);

    $display("[TB] test 2: sparse mask");
    applyStimulus(64'h2000, 32'h8000_0001, pattern);
    checkOutput("t2_waddr0", 64'(mem_waddr), 64'h2000);
    checkOutput("t2_wdata0", 64'(mem_wdata), 64'h00);
    checkOutput("t2_wvalid0", 64'(mem_wvalid), 64'd1);
    @(negedge clock);
    checkOutput("t2_waddr1", 64'(mem_waddr), 64'h201F);
    checkOutput("t2_wdata1", 64'(mem_wdata), 64'h1F);
    checkOutput("t2_wvalid1", 64'(mem_wvalid), 64'd1);
    @(negedge clock);
    checkOutput("t2_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("t2_resp_bytes", 64'(resp_bytes), 64'd2);
    checkOutput("t2_resp_wvalid", 64'(mem_wvalid), 64'd0);
    @(negedge clock);
    checkOutput("t2_idle_busy", 64'(busy), 64'd0);

    $display("[TB] test 3: empty mask");
    applyStimulus(64'h3000, 32'h0, pattern);
    checkOutput("t3_wvalid", 64'(mem_wvalid), 64'd0);
    checkOutput("t3_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("t3_resp_bytes", 64'(resp_bytes), 64'd0);
    @(negedge clock);
    checkOutput("t3_idle_wvalid", 64'(mem_wvalid), 64'd0);
    checkOutput("t3_idle_busy", 64'(busy), 64'd0);

    $display("[TB] test 4: address wrap with stalls");
    mem_wready = 1'b0;
    applyStimulus(64'h7FFF_FFFF, 32'h7, pattern);
    for (int k = 0; k < 3; k++) begin
      logic [30:0] expAddr;
      expAddr = 31'h7FFF_FFFF + 31'(k);
      for (int s = 0; s < 3; s++) begin
        checkOutput($sformatf("t4_stall_wvalid_%0d_%0d", k, s), 64'(mem_wvalid), 64'd1);
        checkOutput($sformatf("t4_stall_waddr_%0d_%0d", k, s), 64'(mem_waddr), 64'(expAddr));
        checkOutput($sformatf("t4_stall_wdata_%0d_%0d", k, s), 64'(mem_wdata), 64'(k));
        @(negedge clock);
      end
      mem_wready = 1'b1;
      checkOutput($sformatf("t4_go_waddr_%0d", k), 64'(mem_waddr), 64'(expAddr));
      @(negedge clock);
      mem_wready = 1'b0;
    end
    checkOutput("t4_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("t4_resp_bytes", 64'(resp_bytes), 64'd3);
    checkOutput("t4_resp_wvalid", 64'(mem_wvalid), 64'd0);
    mem_wready = 1'b1;
    @(negedge clock);
    checkOutput("t4_idle_busy", 64'(busy), 64'd0);

    $display("[TB] test 5: response back-pressure");
    resp_ready = 1'b0;
    req_addr   = 64'h100;
    req_mask   = 32'h1;
    req_data   = pattern;
    req_valid  = 1'b1;
    @(negedge clock);
    checkOutput("t5_waddr", 64'(mem_waddr), 64'h100);
    req_addr = 64'h300;
    req_mask = 32'h3;
    @(negedge clock);
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("t5_hold_resp_valid_%0d", s), 64'(resp_valid), 64'd1);
      checkOutput($sformatf("t5_hold_resp_bytes_%0d", s), 64'(resp_bytes), 64'd1);
      checkOutput($sformatf("t5_hold_req_ready_%0d", s), 64'(req_ready), 64'd0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    checkOutput("t5_hs_resp_valid", 64'(resp_valid), 64'd1);
    @(negedge clock);
    checkOutput("t5_after_busy", 64'(busy), 64'd0);
    checkOutput("t5_after_req_ready", 64'(req_ready), 64'd1);
    checkOutput("t5_after_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clock);
    req_valid = 1'b0;
    checkOutput("t5_second_wvalid0", 64'(mem_wvalid), 64'd1);
    checkOutput("t5_second_waddr0", 64'(mem_waddr), 64'h300);
    @(negedge clock);
    checkOutput("t5_second_waddr1", 64'(mem_waddr), 64'h301);
    checkOutput("t5_second_wdata1", 64'(mem_wdata), 64'h01);
    @(negedge clock);
    checkOutput("t5_second_resp_bytes", 64'(resp_bytes), 64'd2);
    checkOutput("t5_second_resp_valid", 64'(resp_valid), 64'd1);
    @(negedge clock);

    $display("[TB] test 6: reset mid-write");
    applyStimulus(64'h4000, 32'hFFFF_FFFF, pattern);
    @(negedge clock);
    @(negedge clock);
    checkOutput("t6_third_waddr", 64'(mem_waddr), 64'h4002);
    checkOutput("t6_third_wvalid", 64'(mem_wvalid), 64'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_rst_wvalid", 64'(mem_wvalid), 64'd0);
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    checkOutput("t6_rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("t6_rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("t6_rel_req_ready_low", 64'(req_ready), 64'd0);
    @(negedge clock);
    checkOutput("t6_rel_req_ready_high", 64'(req_ready), 64'd1);
    checkOutput("t6_rel_wvalid", 64'(mem_wvalid), 64'd0);
    applyStimulus(64'h10, 32'h5, pattern);
    checkOutput("t6_new_waddr0", 64'(mem_waddr), 64'h10);
    checkOutput("t6_new_wdata0", 64'(mem_wdata), 64'h00);
    @(negedge clock);
    checkOutput("t6_new_waddr1", 64'(mem_waddr), 64'h12);
    checkOutput("t6_new_wdata1", 64'(mem_wdata), 64'h02);
    @(negedge clock);
    checkOutput("t6_new_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("t6_new_resp_bytes", 64'(resp_bytes), 64'd2);
    @(negedge clock);
    checkOutput("t6_new_idle_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
